// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision constants and the converter FSM state type.
package fp_pkg;
  localparam int FP_BIAS   = 127;
  localparam int FP_EXP_W  = 8;
  localparam int FP_FRAC_W = 23;

  // Field positions inside a packed single-precision word
  localparam int FP_SIGN_POS = 31;
  localparam int FP_EXP_MSB  = 30;
  localparam int FP_EXP_LSB  = 23;
  localparam int FP_FRAC_MSB = 22;
  localparam int FP_FRAC_LSB = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    PACK = 2'd2,
    DONE = 2'd3
  } conv_state_t;
endpackage

// File: rtl/fp_round_pack.sv
// Combinational round-to-nearest-even and pack of a normalized mantissa into a single-precision word.
module fp_round_pack
  import fp_pkg::*;
#(
  parameter int IN_W   = 32,
  parameter int FRAC_W = 30,
  parameter int SW     = $clog2(IN_W)
) (
  input  logic [IN_W-1:0] mant,
  input  logic [SW-1:0]   shift,
  input  logic            sign,
  input  logic            zero,
  output logic [31:0]     word
);
  localparam logic [9:0] EXP_BASE = 10'(FP_BIAS + IN_W - 1 - FRAC_W);

  logic [FP_FRAC_W-1:0] frac;
  logic                 guard;
  logic                 sticky;
  logic                 round_up;
  logic [FP_FRAC_W:0]   frac_sum;
  logic [9:0]           exp_raw;
  logic [9:0]           exp_fin;
  logic                 force_zero;

  assign frac     = mant[IN_W-2 -: FP_FRAC_W];
  assign guard    = mant[IN_W-25];
  assign sticky   = |mant[IN_W-26:0];
  assign round_up = guard & (sticky | frac[0]);

  // An all-ones fraction that rounds up carries into the exponent and leaves the fraction zero
  assign frac_sum = {1'b0, frac} + {{FP_FRAC_W{1'b0}}, round_up};
  assign exp_raw  = EXP_BASE - {{(10-SW){1'b0}}, shift};
  assign exp_fin  = exp_raw + {9'd0, frac_sum[FP_FRAC_W]};

  // A missing hidden bit or an out-of-range exponent can only mean a zero operand
  assign force_zero = zero | ~mant[IN_W-1] | (|exp_fin[9:8]);

  always_comb begin
    word = '0;
    if (!force_zero) begin
      word[FP_SIGN_POS]               = sign;
      word[FP_EXP_MSB:FP_EXP_LSB]     = exp_fin[FP_EXP_W-1:0];
      word[FP_FRAC_MSB:FP_FRAC_LSB]   = frac_sum[FP_FRAC_W-1:0];
    end
  end
endmodule

// File: rtl/fixed_to_floating_point.sv
// Signed fixed-point to IEEE-754 single converter; normalizes one bit per cycle, then rounds and packs.
module fixed_to_floating_point
  import fp_pkg::*;
#(
  parameter int IN_W   = 32,
  parameter int FRAC_W = 30
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_data
);
  localparam int SW = $clog2(IN_W);

  conv_state_t     state, next_state;
  logic [IN_W-1:0] mag;
  logic [SW-1:0]   s;
  logic            sign;
  logic            zero;
  logic [31:0]     packed_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (in_valid) next_state = NORM;
      NORM: if (mag == '0 || mag[IN_W-1]) next_state = PACK;
      PACK: next_state = DONE;
      DONE: if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag       <= '0;
      s         <= '0;
      sign      <= 1'b0;
      zero      <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          // The most-negative operand negates to 2^(IN_W-1), still representable unsigned
          sign <= in_data[IN_W-1];
          mag  <= in_data[IN_W-1] ? (~in_data + 1'b1) : in_data;
          s    <= '0;
          zero <= 1'b0;
        end
        NORM: begin
          if (mag == '0) begin
            zero <= 1'b1;
          end else if (!mag[IN_W-1]) begin
            mag <= mag << 1;
            s   <= s + SW'(1);
          end
        end
        PACK: begin
          out_data  <= packed_word;
          out_valid <= 1'b1;
        end
        DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  // Zero is detected in the final NORM cycle, so the packer sees the live condition too
  fp_round_pack #(
    .IN_W   (IN_W),
    .FRAC_W (FRAC_W),
    .SW     (SW)
  ) u_round_pack (
    .mant  (mag),
    .shift (s),
    .sign  (sign),
    .zero  (zero | (mag == '0)),
    .word  (packed_word)
  );
endmodule
